// File: rtl/bs_dispatch_controller.sv
// Multi-engine dispatcher for the Black-Scholes array: issues start pulses, round-robin
// operand fetches, tracks in-flight jobs per engine, drains at end of data and runs a watchdog.
module bs_dispatch_controller #(
    parameter int NUM_ENGINES     = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CYCLE_CNT_WIDTH = 32,
    parameter int JOB_CNT_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start_system,
    input  logic                       abort,
    input  logic                       out_of_data,
    input  logic [NUM_ENGINES-1:0]     bs_ready,
    input  logic [NUM_ENGINES-1:0]     bs_done,
    input  logic [NUM_ENGINES-1:0]     bs_idle,
    input  logic [NUM_ENGINES-1:0]     has_unused_data,
    input  logic [NUM_ENGINES-1:0]     reg_ready,
    output logic [NUM_ENGINES-1:0]     bs_start,
    output logic [NUM_ENGINES-1:0]     serve_reg,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout_err,
    output logic                       spurious_done,
    output logic [CYCLE_CNT_WIDTH-1:0] cycle_count,
    output logic [JOB_CNT_WIDTH-1:0]   jobs_done,
    output logic [7:0]                 led
);

    localparam int          PTR_W    = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [2:0]  MAX_OUT  = 3'(MAX_OUTSTANDING);
    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERROR} state_t;

    state_t                 state, state_next;
    logic [2:0]             outstanding [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] serve_pending;
    logic [PTR_W-1:0]       rr_ptr, next_ptr;
    logic [31:0]            wd_timer;
    logic                   ood_q;

    logic [NUM_ENGINES-1:0] nonzero, below_max, qualify, request, grant;
    logic [NUM_ENGINES-1:0] valid_done, stray_done;
    logic [4:0]             pop;
    logic [JOB_CNT_WIDTH:0] jobs_sum;
    logic                   active, activity, wd_expire, all_clear, launch, start_run, found;
    int unsigned            idx;

    always_comb begin
        nonzero   = '0;
        below_max = '0;
        pop       = '0;
        for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
            nonzero[i]   = (outstanding[i] != 3'd0);
            below_max[i] = (outstanding[i] < MAX_OUT);
        end
        // a done is genuine if a job is in flight or one is starting this very cycle
        valid_done = bs_done & (nonzero | bs_start);
        stray_done = bs_done & ~nonzero & ~bs_start;
        for (int unsigned i = 0; i < NUM_ENGINES; i++)
            pop = pop + 5'(valid_done[i]);
        jobs_sum  = (JOB_CNT_WIDTH+1)'(jobs_done) + (JOB_CNT_WIDTH+1)'(pop);
        active    = ((state == S_RUN) || (state == S_DRAIN)) && !abort;
        activity  = (|bs_start) || (|valid_done);
        wd_expire = (TIMEOUT_CYCLES != 0) && !activity && (wd_timer == WD_LIMIT);
        all_clear = (nonzero == '0) && (&bs_idle);
        qualify   = has_unused_data & reg_ready & bs_ready & below_max & ~bs_start;
        request   = ~has_unused_data & ~serve_pending & {NUM_ENGINES{~out_of_data}};
    end

    always_comb begin
        grant    = '0;
        next_ptr = rr_ptr;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_ENGINES;
            if (!found && request[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = PTR_W'((idx + 1) % NUM_ENGINES);
            end
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start_system) state_next = S_RUN;
                S_RUN: begin
                    if (wd_expire)                                   state_next = S_ERROR;
                    else if (out_of_data && (has_unused_data == '0)) state_next = S_DRAIN;
                end
                S_DRAIN: begin
                    if (wd_expire)      state_next = S_ERROR;
                    else if (all_clear) state_next = S_DONE;
                end
                default: state_next = state;
            endcase
        end
        launch    = (state == S_RUN) && (state_next == S_RUN);
        start_run = ((state == S_IDLE) || (state == S_DONE)) && start_system && !abort;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= S_IDLE;
            bs_start      <= '0;
            serve_reg     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            spurious_done <= 1'b0;
            cycle_count   <= '0;
            jobs_done     <= '0;
            serve_pending <= '0;
            rr_ptr        <= '0;
            wd_timer      <= '0;
            ood_q         <= 1'b0;
            for (int unsigned i = 0; i < NUM_ENGINES; i++) outstanding[i] <= '0;
        end else begin
            state       <= state_next;
            busy        <= (state_next == S_RUN) || (state_next == S_DRAIN);
            done        <= (state_next == S_DONE);
            timeout_err <= (state_next == S_ERROR);
            ood_q       <= out_of_data;
            bs_start    <= launch ? qualify : '0;
            serve_reg   <= launch ? grant : '0;
            if (launch && found) rr_ptr <= next_ptr;
            serve_pending <= (serve_pending | (launch ? grant : '0)) & ~has_unused_data
                             & ~{NUM_ENGINES{out_of_data & ~ood_q}};

            if (start_run) begin
                cycle_count   <= '0;
                jobs_done     <= '0;
                spurious_done <= 1'b0;
                wd_timer      <= '0;
                for (int unsigned i = 0; i < NUM_ENGINES; i++) outstanding[i] <= '0;
            end else if (active) begin
                if (cycle_count != '1) cycle_count <= cycle_count + CYCLE_CNT_WIDTH'(1);
                if (jobs_sum[JOB_CNT_WIDTH]) jobs_done <= '1;
                else                         jobs_done <= jobs_sum[JOB_CNT_WIDTH-1:0];
                if (stray_done != '0) spurious_done <= 1'b1;
                if (activity)                 wd_timer <= '0;
                else if (TIMEOUT_CYCLES != 0) wd_timer <= wd_timer + 32'd1;
                for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
                    if (bs_start[i] && !valid_done[i])      outstanding[i] <= outstanding[i] + 3'd1;
                    else if (!bs_start[i] && valid_done[i]) outstanding[i] <= outstanding[i] - 3'd1;
                end
            end
        end
    end

    assign led = cycle_count[7:0];

endmodule

// File: tb/tb_bs_dispatch_controller.sv
// Directed self-checking bench for bs_dispatch_controller (4 engines, 2 outstanding, 16-cycle watchdog).
module tb_bs_dispatch_controller;

    logic        clock = 1'b0;
    logic        reset, start_system, abort, out_of_data;
    logic [3:0]  bs_ready, bs_done, bs_idle, has_unused_data, reg_ready;
    logic [3:0]  bs_start, serve_reg;
    logic        busy, done, timeout_err, spurious_done;
    logic [31:0] cycle_count;
    logic [15:0] jobs_done;
    logic [7:0]  led;

    int n_cmp  = 0;
    int n_fail = 0;

    bs_dispatch_controller #(
        .NUM_ENGINES(4), .MAX_OUTSTANDING(2), .CYCLE_CNT_WIDTH(32),
        .JOB_CNT_WIDTH(16), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock), .reset(reset), .start_system(start_system), .abort(abort),
        .out_of_data(out_of_data), .bs_ready(bs_ready), .bs_done(bs_done), .bs_idle(bs_idle),
        .has_unused_data(has_unused_data), .reg_ready(reg_ready), .bs_start(bs_start),
        .serve_reg(serve_reg), .busy(busy), .done(done), .timeout_err(timeout_err),
        .spurious_done(spurious_done), .cycle_count(cycle_count), .jobs_done(jobs_done), .led(led)
    );

    always #5 clock = ~clock;

    // inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic defaults;
        start_system = 1'b0; abort = 1'b0; out_of_data = 1'b0;
        bs_ready = '0; bs_done = '0; bs_idle = 4'b1111; has_unused_data = '0; reg_ready = '0;
    endtask

    task automatic do_reset;
        defaults();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic pulse_start;
        start_system = 1'b1;
        tick();
        start_system = 1'b0;
    endtask

    task automatic test_reset;
        defaults();
        reset = 1'b0;
        start_system = 1'b1; has_unused_data = 4'b1111; reg_ready = 4'b1111; bs_ready = 4'b1111;
        tick(); tick();
        n_cmp++; if (bs_start !== 4'b0) begin n_fail++; $display("FAIL rst_bs_start got %b want 0000", bs_start); end
        n_cmp++; if (serve_reg !== 4'b0) begin n_fail++; $display("FAIL rst_serve got %b want 0000", serve_reg); end
        n_cmp++; if ({busy, done, timeout_err, spurious_done} !== 4'b0) begin n_fail++; $display("FAIL rst_flags got %b want 0000", {busy, done, timeout_err, spurious_done}); end
        n_cmp++; if (cycle_count !== 32'd0 || jobs_done !== 16'd0 || led !== 8'd0) begin n_fail++; $display("FAIL rst_counts got %0d/%0d/%0d want 0/0/0", cycle_count, jobs_done, led); end
        defaults();
        reset = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
        has_unused_data = 4'b1111;
        pulse_start();
        n_cmp++; if (busy !== 1'b1 || cycle_count !== 32'd0) begin n_fail++; $display("FAIL run_entry busy=%b cc=%0d want 1/0", busy, cycle_count); end
        tick(); tick(); tick();
        n_cmp++; if (cycle_count !== 32'd3 || led !== 8'd3) begin n_fail++; $display("FAIL led_track cc=%0d led=%0d want 3/3", cycle_count, led); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_seq [6];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
        do_reset();
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (serve_reg !== exp_seq[i]) begin n_fail++; $display("FAIL rr_seq%0d got %b want %b", i, serve_reg, exp_seq[i]); end
        end
        has_unused_data = 4'b0010;
        tick();
        n_cmp++; if (serve_reg !== 4'b0000) begin n_fail++; $display("FAIL rr_loaded got %b want 0000", serve_reg); end
        has_unused_data = 4'b0000;
        tick();
        n_cmp++; if (serve_reg !== 4'b0010) begin n_fail++; $display("FAIL rr_reissue got %b want 0010", serve_reg); end
    endtask

    task automatic test_outstanding;
        do_reset();
        has_unused_data = 4'b0001; reg_ready = 4'b0001; bs_ready = 4'b0001;
        pulse_start();
        tick();
        n_cmp++; if (bs_start !== 4'b0001) begin n_fail++; $display("FAIL os_t1 got %b want 0001", bs_start); end
        tick();
        n_cmp++; if (bs_start !== 4'b0000) begin n_fail++; $display("FAIL os_t2 got %b want 0000", bs_start); end
        tick();
        n_cmp++; if (bs_start !== 4'b0001) begin n_fail++; $display("FAIL os_t3 got %b want 0001", bs_start); end
        tick(); tick();
        n_cmp++; if (bs_start !== 4'b0000) begin n_fail++; $display("FAIL os_limit got %b want 0000", bs_start); end
        bs_done = 4'b0001;
        tick();
        bs_done = 4'b0000;
        n_cmp++; if (bs_start !== 4'b0000 || jobs_done !== 16'd1) begin n_fail++; $display("FAIL os_done1 bs_start=%b jobs=%0d want 0000/1", bs_start, jobs_done); end
        tick();
        n_cmp++; if (bs_start !== 4'b0001) begin n_fail++; $display("FAIL os_restart got %b want 0001", bs_start); end
        bs_done = 4'b0001;
        tick();
        bs_done = 4'b0000;
        n_cmp++; if (bs_start !== 4'b0000 || jobs_done !== 16'd2) begin n_fail++; $display("FAIL os_same bs_start=%b jobs=%0d want 0000/2", bs_start, jobs_done); end
        tick();
        n_cmp++; if (bs_start !== 4'b0001) begin n_fail++; $display("FAIL os_after_same got %b want 0001", bs_start); end
        tick(); tick();
        n_cmp++; if (bs_start !== 4'b0000) begin n_fail++; $display("FAIL os_full_again got %b want 0000", bs_start); end
        n_cmp++; if (spurious_done !== 1'b0) begin n_fail++; $display("FAIL os_spurious got %b want 0", spurious_done); end
    endtask

    task automatic test_drain;
        do_reset();
        has_unused_data = 4'b0111; reg_ready = 4'b0111; bs_ready = 4'b0111; bs_idle = 4'b0000;
        pulse_start();
        tick();
        n_cmp++; if (bs_start !== 4'b0111) begin n_fail++; $display("FAIL dr_start got %b want 0111", bs_start); end
        has_unused_data = 4'b0000; out_of_data = 1'b1;
        tick();
        n_cmp++; if (bs_start !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL dr_enter bs_start=%b busy=%b done=%b want 0000/1/0", bs_start, busy, done); end
        bs_done = 4'b0001; tick();
        bs_done = 4'b0010; tick();
        bs_done = 4'b0100; tick();
        bs_done = 4'b0000;
        n_cmp++; if (jobs_done !== 16'd3 || done !== 1'b0) begin n_fail++; $display("FAIL dr_jobs jobs=%0d done=%b want 3/0", jobs_done, done); end
        bs_idle = 4'b1111;
        tick();
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || cycle_count !== 32'd6) begin n_fail++; $display("FAIL dr_done done=%b busy=%b cc=%0d want 1/0/6", done, busy, cycle_count); end
        tick(); tick(); tick();
        n_cmp++; if (cycle_count !== 32'd6 || led !== 8'd6 || done !== 1'b1) begin n_fail++; $display("FAIL dr_frozen cc=%0d led=%0d done=%b want 6/6/1", cycle_count, led, done); end
        out_of_data = 1'b0; has_unused_data = 4'b1111;
        pulse_start();
        n_cmp++; if (busy !== 1'b1 || cycle_count !== 32'd0 || jobs_done !== 16'd0) begin n_fail++; $display("FAIL dr_rerun busy=%b cc=%0d jobs=%0d want 1/0/0", busy, cycle_count, jobs_done); end
    endtask

    task automatic test_timeout;
        do_reset();
        has_unused_data = 4'b1111;
        pulse_start();
        for (int i = 0; i < 15; i++) tick();
        n_cmp++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wd_early err=%b busy=%b want 0/1", timeout_err, busy); end
        tick();
        n_cmp++; if (timeout_err !== 1'b1 || busy !== 1'b0 || cycle_count !== 32'd16) begin n_fail++; $display("FAIL wd_fire err=%b busy=%b cc=%0d want 1/0/16", timeout_err, busy, cycle_count); end
        pulse_start();
        tick();
        n_cmp++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL wd_hold err=%b busy=%b want 1/0", timeout_err, busy); end
        abort = 1'b1; tick(); abort = 1'b0;
        n_cmp++; if (timeout_err !== 1'b0 || cycle_count !== 32'd16) begin n_fail++; $display("FAIL wd_abort err=%b cc=%0d want 0/16", timeout_err, cycle_count); end
    endtask

    task automatic test_spurious;
        do_reset();
        has_unused_data = 4'b1111;
        pulse_start();
        bs_done = 4'b0100;
        tick();
        bs_done = 4'b0000;
        n_cmp++; if (spurious_done !== 1'b1 || jobs_done !== 16'd0) begin n_fail++; $display("FAIL sp_set sp=%b jobs=%0d want 1/0", spurious_done, jobs_done); end
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        n_cmp++; if (spurious_done !== 1'b1) begin n_fail++; $display("FAIL sp_sticky got %b want 1", spurious_done); end
        pulse_start();
        n_cmp++; if (spurious_done !== 1'b0) begin n_fail++; $display("FAIL sp_clear got %b want 0", spurious_done); end
    endtask

    task automatic test_abort;
        do_reset();
        has_unused_data = 4'b0001; reg_ready = 4'b0001; bs_ready = 4'b0001;
        pulse_start();
        tick();
        n_cmp++; if (bs_start !== 4'b0001) begin n_fail++; $display("FAIL ab_pre got %b want 0001", bs_start); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++; if (bs_start !== 4'b0000 || serve_reg !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL ab_idle bs_start=%b serve=%b busy=%b want 0000/0000/0", bs_start, serve_reg, busy); end
        tick(); tick();
        n_cmp++; if (bs_start !== 4'b0000 || cycle_count !== 32'd1) begin n_fail++; $display("FAIL ab_held bs_start=%b cc=%0d want 0000/1", bs_start, cycle_count); end
        pulse_start();
        n_cmp++; if (busy !== 1'b1 || cycle_count !== 32'd0) begin n_fail++; $display("FAIL ab_restart busy=%b cc=%0d want 1/0", busy, cycle_count); end
        tick();
        n_cmp++; if (bs_start !== 4'b0001) begin n_fail++; $display("FAIL ab_restart_start got %b want 0001", bs_start); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_outstanding();
        test_drain();
        test_timeout();
        test_spurious();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
